hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline stall/forward unit of the 5-stage MIPS core.
- Tracks destination register, write-enable and Tnew for the E/M/W stages in its own pipeline registers, so the datapath supplies only D-stage Tnew.
- Adds stalls against producers in M (not only E).
- Adds a multi-cycle mult/div busy counter with HI/LO stalls, and corrects M-stage store-data forwarding to key on the store's rt.

Parameters:
- REG_AW, 5, register address width.
- TW, 2, width of Tuse/Tnew fields.
- MULT_CYCLES, 5, mult latency after start.
- DIV_CYCLES, 10, div latency after start.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- tuse_rs  in  TW  D-stage cycles until rs needed.
- tuse_rt  in  TW  D-stage cycles until rt needed.
- tnew_d  in  TW  cycles after entering E until the D instruction's result exists.
- rs_d, rt_d  in  REG_AW  D-stage source registers.
- write_reg_d  in  REG_AW  D-stage destination.
- reg_write_d  in  1  D instruction writes the register file.
- md_use_d  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- rs_e, rt_e  in  REG_AW  E-stage source registers.
- md_start_e  in  1  E-stage instruction starts mult/div.
- md_is_div_e  in  1  qualifies md_start_e: 1=div.
- rt_m  in  REG_AW  M-stage store data register.
- mem_write_m  in  1  M-stage instruction is a store.
- stall_f, stall_d, flush_e  out  1  freeze PC/IF-ID, bubble ID-EX.
- fwd_a_d, fwd_b_d  out  1  D compare operands from M result.
- fwd_a_e, fwd_b_e  out  2  00 regfile, 10 from M, 01 from W.
- fwd_m  out  1  store data from W result.
- md_busy  out  1  mult/div unit busy.

Behaviour:
- Internal stage records {wr, we, tnew} for E, M, W, updated each posedge clk.
  - reset: all records cleared to {0,0,0}; md count = 0.
  - E <= {write_reg_d, reg_write_d, tnew_d}, or a zeroed bubble when flush_e=1.
  - M <= E with tnew saturating-decremented (0 stays 0).
  - W <= M with tnew saturating-decremented.
  - The unit never stalls E/M/W.
- stall_rs = rs_d!=0 and either:
  - rs_d==wr_E & we_E & tuse_rs<tnew_E, or
  - rs_d==wr_M & we_M & tuse_rs<tnew_M.
  - stall_rt is identical using rt_d/tuse_rt.
- stall_md = md_use_d & (md_busy | md_start_e).
- stall_f = stall_d = flush_e = stall_rs | stall_rt | stall_md.
- All stall/flush/forward outputs are purely combinational from inputs and records. After reset they evaluate to 0 unless the inputs create a hazard.
- fwd_a_d = rs_d!=0 & rs_d==wr_M & we_M & tnew_M==0. fwd_b_d is the same with rt_d. W→D forwarding is handled by the regfile bypass and is not driven here.
- fwd_a_e priority, with X=rs_e:
  - 10 if X!=0 & X==wr_M & we_M & tnew_M==0;
  - else 00 if X matches M (M pending; a stall has already covered it);
  - else 01 if X==wr_W & we_W & tnew_W==0;
  - else 00.
  - fwd_b_e is the same with rt_e.
- fwd_m = mem_write_m & rt_m!=0 & rt_m==wr_W & we_W & tnew_W==0.
- md counter:
  - Loads MULT_CYCLES or DIV_CYCLES on the posedge where md_start_e=1. A start while busy reloads.
  - Otherwise decrements if nonzero.
  - md_busy = count!=0.
  - Counter width = clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- Register $0 never causes a stall or forward.
- reset asserted mid-stall clears the records and counter. Stall deasserts in the same cycle the reset edge takes effect, unless D inputs alone still hazard against md_start_e.
- Simultaneous stall and md_start_e: the counter loads normally; the bubble enters E.

Test Plan:
- lw $8 (tnew_d=2, we=1) then add using $8 as rs (tuse_rs=1) → exactly 1 cycle of stall_f=stall_d=flush_e=1. The next cycle has fwd_a_d=0; when add is in E, fwd_a_e=01.
- lw $8 then beq $8 (tuse_rs=0) → 2 stall cycles (E match, then M match with tnew_M=1), then no stall and fwd_a_d=0.
- addu $9 (tnew_d=1) then sw with rt=$9 → no stall. When sw is in M and addu in W, fwd_m=1.
- addu $9 then subu $10,$9,$9 → fwd_a_e=fwd_b_e=10. Same case with one independent instruction between → 01.
- mult in E (md_start_e=1, md_is_div_e=0) then mfhi in D → stall for MULT_CYCLES+1=6 cycles; md_busy high for 5. With div → 11 stall cycles.
- Writes to $0 with dependent reader, and reset pulsed during a div stall → no stall/forward for $0. After reset: md_busy=0 and all outputs 0 with idle inputs.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Stall/forward unit with self-tracked E/M/W destination records and a mult/div busy counter.
// Outputs are combinational from inputs and records; records advance every clock and never stall.
module hazard_scoreboard #(
    parameter int REG_AW      = 5,
    parameter int TW          = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TW-1:0]     tuse_rs,
    input  logic [TW-1:0]     tuse_rt,
    input  logic [TW-1:0]     tnew_d,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] write_reg_d,
    input  logic              reg_write_d,
    input  logic              md_use_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic              md_start_e,
    input  logic              md_is_div_e,
    input  logic [REG_AW-1:0] rt_m,
    input  logic              mem_write_m,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_e,
    output logic              fwd_a_d,
    output logic              fwd_b_d,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              fwd_m,
    output logic              md_busy
);

    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW     = $clog2(MD_MAX + 1);

    typedef struct packed {
        logic [REG_AW-1:0] wr;
        logic              we;
        logic [TW-1:0]     tnew;
    } rec_t;

    rec_t          rec_e, rec_m, rec_w;
    logic [CW-1:0] md_cnt;
    logic          stall_rs, stall_rt, stall_md, stall;

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
        return (t == '0) ? t : t - TW'(1);
    endfunction

    // A live producer of src in a stage record; $0 never matches.
    function automatic logic hit(input logic [REG_AW-1:0] src, input rec_t r);
        return (src != '0) && (src == r.wr) && r.we;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] src, input rec_t m, input rec_t w);
        logic [1:0] sel;
        sel = 2'b00;
        if (hit(src, m)) begin
            sel = (m.tnew == '0) ? 2'b10 : 2'b00;
        end else if (hit(src, w) && (w.tnew == '0)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            rec_e <= '0;
            rec_m <= '0;
            rec_w <= '0;
        end else begin
            rec_e <= stall ? '0 : rec_t'{write_reg_d, reg_write_d, tnew_d};
            rec_m <= rec_t'{rec_e.wr, rec_e.we, dec_sat(rec_e.tnew)};
            rec_w <= rec_t'{rec_m.wr, rec_m.we, dec_sat(rec_m.tnew)};
        end
    end

    // A start reloads even when the unit is already busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (md_start_e) begin
            md_cnt <= md_is_div_e ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CW'(1);
        end
    end

    always_comb begin
        md_busy  = (md_cnt != '0);
        stall_rs = (hit(rs_d, rec_e) && (tuse_rs < rec_e.tnew)) ||
                   (hit(rs_d, rec_m) && (tuse_rs < rec_m.tnew));
        stall_rt = (hit(rt_d, rec_e) && (tuse_rt < rec_e.tnew)) ||
                   (hit(rt_d, rec_m) && (tuse_rt < rec_m.tnew));
        stall_md = md_use_d && (md_busy || md_start_e);
        stall    = stall_rs || stall_rt || stall_md;
        stall_f  = stall;
        stall_d  = stall;
        flush_e  = stall;
        fwd_a_d  = hit(rs_d, rec_m) && (rec_m.tnew == '0);
        fwd_b_d  = hit(rt_d, rec_m) && (rec_m.tnew == '0);
        fwd_a_e  = fwd_e(rs_e, rec_m, rec_w);
        fwd_b_e  = fwd_e(rt_e, rec_m, rec_w);
        fwd_m    = mem_write_m && hit(rt_m, rec_w) && (rec_w.tnew == '0);
    end

endmodule
